// File: rtl/duck_round_scheduler_pkg.sv
// duck_round_scheduler_pkg: state encoding, default frame timing and
// counter sizing helpers for the duck hunt round scheduler.
package duck_round_scheduler_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    INTRO     = 4'd1,
    SPAWN     = 4'd2,
    FLY       = 4'd3,
    HIT       = 4'd4,
    ESCAPE    = 4'd5,
    SHOW      = 4'd6,
    ROUND_END = 4'd7,
    DONE      = 4'd8
  } sched_state_t;

  localparam int DEF_DUCKS_PER_ROUND = 10;
  localparam int DEF_ROUNDS          = 5;
  localparam int DEF_INTRO_FRAMES    = 120;
  localparam int DEF_FLIGHT_FRAMES   = 300;
  localparam int DEF_FALL_FRAMES     = 40;
  localparam int DEF_SHOW_FRAMES     = 60;
  localparam int DEF_SPEEDUP_STEP    = 30;
  localparam int DEF_MIN_FLIGHT      = 120;

  localparam int ENEMY_SCORE_MAX = 99;
  localparam int MIN_CNT_W       = 9;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int cnt_width(input int mx);
    int w;
    w = 30;
    for (int i = 30; i >= 1; i--) begin
      if ((1 << i) > mx) w = i;
    end
    return max_i(w, MIN_CNT_W);
  endfunction

endpackage

// File: rtl/duck_round_scheduler_if.sv
// duck_round_scheduler_if: game-control side bundle of the round
// scheduler; master is the scheduler, slave is game control.
interface duck_round_scheduler_if;

  logic       game_enable;
  logic       game_start;
  logic       frame_tick;
  logic       intro_done;
  logic       duck_killed;
  logic       hunt_start;
  logic       duck_respawn;
  logic       dog_bird_enable;
  logic       dog_laugh;
  logic [6:0] enemy_score;
  logic [3:0] round_num;
  logic [3:0] duck_num;
  logic       rounds_finished;
  logic [3:0] state_o;

  modport master (
    input  game_enable,
    input  game_start,
    input  frame_tick,
    input  intro_done,
    input  duck_killed,
    output hunt_start,
    output duck_respawn,
    output dog_bird_enable,
    output dog_laugh,
    output enemy_score,
    output round_num,
    output duck_num,
    output rounds_finished,
    output state_o
  );

  modport slave (
    output game_enable,
    output game_start,
    output frame_tick,
    output intro_done,
    output duck_killed,
    input  hunt_start,
    input  duck_respawn,
    input  dog_bird_enable,
    input  dog_laugh,
    input  enemy_score,
    input  round_num,
    input  duck_num,
    input  rounds_finished,
    input  state_o
  );

endinterface

// File: rtl/duck_round_scheduler_frame_timer.sv
// duck_round_scheduler_frame_timer: frame counter with clear, tick
// enable and a terminal-count compare against a supplied limit.
module duck_round_scheduler_frame_timer #(
  parameter int CW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_tick,
  input  logic [CW-1:0] i_lim,
  output logic          o_tc
);

  logic [CW-1:0] r_cnt;

  // saturate so a long idle stretch never wraps back under the limit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_tick && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt >= i_lim);

endmodule

// File: rtl/duck_round_scheduler.sv
// duck_round_scheduler: sequences intro, spawn, flight, hit/escape and
// dog reaction per duck and round. Option: DUCK_SCHED_SPEEDUP_EN.
module duck_round_scheduler
  import duck_round_scheduler_pkg::*;
#(
  parameter int DUCKS_PER_ROUND   = DEF_DUCKS_PER_ROUND,
  parameter int ROUNDS            = DEF_ROUNDS,
  parameter int INTRO_FRAMES      = DEF_INTRO_FRAMES,
  parameter int FLIGHT_FRAMES     = DEF_FLIGHT_FRAMES,
  parameter int FALL_FRAMES       = DEF_FALL_FRAMES,
  parameter int SHOW_FRAMES       = DEF_SHOW_FRAMES,
  parameter int SPEEDUP_STEP      = DEF_SPEEDUP_STEP,
  parameter int MIN_FLIGHT_FRAMES = DEF_MIN_FLIGHT
) (
  input  logic                   clk,
  input  logic                   rst,
  duck_round_scheduler_if.master bus
);

  localparam int MAX_F = max_i(
    max_i(max_i(INTRO_FRAMES, FLIGHT_FRAMES),
          max_i(FALL_FRAMES, SHOW_FRAMES)),
    max_i(SPEEDUP_STEP, MIN_FLIGHT_FRAMES));
  localparam int CW = cnt_width(MAX_F);

  localparam logic [3:0] ST_IDLE      = IDLE;
  localparam logic [3:0] ST_INTRO     = INTRO;
  localparam logic [3:0] ST_SPAWN     = SPAWN;
  localparam logic [3:0] ST_FLY       = FLY;
  localparam logic [3:0] ST_HIT       = HIT;
  localparam logic [3:0] ST_ESCAPE    = ESCAPE;
  localparam logic [3:0] ST_SHOW      = SHOW;
  localparam logic [3:0] ST_ROUND_END = ROUND_END;
  localparam logic [3:0] ST_DONE      = DONE;

  localparam logic [3:0] LAST_DUCK  = 4'(DUCKS_PER_ROUND - 1);
  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);
  localparam logic [6:0] SCORE_MAX  = 7'(ENEMY_SCORE_MAX);

  logic [3:0]    r_state;
  logic [3:0]    w_nxt;
  logic          w_clr;
  logic          w_tc;
  logic [CW-1:0] w_lim;
  logic [CW-1:0] w_flight;
  logic          w_start;
  logic          w_esc;
  logic          r_last_hit;
  logic          w_lh_nxt;
  logic [6:0]    r_score;
  logic [3:0]    r_round;
  logic [3:0]    r_duck;
  logic          r_hunt;
  logic          r_respawn;
  logic          r_bird;
  logic          r_laugh;
  logic          r_finished;
  logic [3:0]    r_state_o;

  assign w_start = (r_state == ST_IDLE) && bus.game_enable
                   && bus.game_start;
  // a kill in the timeout cycle wins, so the escape needs !duck_killed
  assign w_esc = (r_state == ST_FLY) && bus.game_enable
                 && !bus.duck_killed && w_tc;

`ifdef DUCK_SCHED_SPEEDUP_EN
  localparam int SW = CW + 5;

  logic [3:0]    w_nrnd;
  logic [SW-1:0] w_red;
  logic [CW-1:0] w_fl_calc;
  logic [CW-1:0] r_flight;

  // limit for the round about to start, registered ahead of FLY
  assign w_nrnd = (r_state == ST_IDLE) ? 4'd0 : r_round + 4'd1;
  assign w_red  = SW'(w_nrnd) * SW'(SPEEDUP_STEP);
  assign w_fl_calc =
    (SW'(FLIGHT_FRAMES) >= w_red + SW'(MIN_FLIGHT_FRAMES))
      ? CW'(SW'(FLIGHT_FRAMES) - w_red)
      : CW'(MIN_FLIGHT_FRAMES);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_flight <= CW'(FLIGHT_FRAMES);
    end else if ((r_state == ST_IDLE)
                 || (r_state == ST_ROUND_END)) begin
      r_flight <= w_fl_calc;
    end
  end

  assign w_flight = r_flight;
`else
  assign w_flight = CW'(FLIGHT_FRAMES);
`endif

  always_comb begin
    w_lim = '0;
    unique case (1'b1)
      (r_state == ST_INTRO): w_lim = CW'(INTRO_FRAMES);
      (r_state == ST_FLY):   w_lim = w_flight;
      (r_state == ST_HIT):   w_lim = CW'(FALL_FRAMES);
      (r_state == ST_SHOW):  w_lim = CW'(SHOW_FRAMES);
      default:               w_lim = '0;
    endcase
  end

  always_comb begin
    w_nxt = r_state;
    if (!bus.game_enable) begin
      w_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.game_start) w_nxt = ST_INTRO;
        end
        ST_INTRO: begin
          if (bus.intro_done || w_tc) w_nxt = ST_SPAWN;
        end
        ST_SPAWN: w_nxt = ST_FLY;
        ST_FLY: begin
          if (bus.duck_killed) w_nxt = ST_HIT;
          else if (w_tc)       w_nxt = ST_ESCAPE;
        end
        ST_HIT: begin
          if (w_tc) w_nxt = ST_SHOW;
        end
        ST_ESCAPE: w_nxt = ST_SHOW;
        ST_SHOW: begin
          if (w_tc) begin
            w_nxt = (r_duck == LAST_DUCK) ? ST_ROUND_END
                                          : ST_SPAWN;
          end
        end
        ST_ROUND_END: begin
          w_nxt = (r_round == LAST_ROUND) ? ST_DONE : ST_INTRO;
        end
        ST_DONE: w_nxt = ST_DONE;
        default: w_nxt = ST_IDLE;
      endcase
    end
  end

  assign w_clr = (w_nxt != r_state);

  duck_round_scheduler_frame_timer #(
    .CW (CW)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .i_tick (bus.frame_tick),
    .i_lim  (w_lim),
    .o_tc   (w_tc)
  );

  always_comb begin
    w_lh_nxt = r_last_hit;
    if (r_state == ST_HIT)    w_lh_nxt = 1'b1;
    if (r_state == ST_ESCAPE) w_lh_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_last_hit <= 1'b0;
      r_score    <= '0;
      r_round    <= '0;
      r_duck     <= '0;
    end else begin
      r_state    <= w_nxt;
      r_last_hit <= w_lh_nxt;
      if (w_start) begin
        r_score <= '0;
      end else if (w_esc && (r_score < SCORE_MAX)) begin
        r_score <= r_score + 7'd1;
      end
      if (w_start) begin
        r_round <= '0;
      end else if ((r_state == ST_ROUND_END)
                   && (w_nxt == ST_INTRO)) begin
        r_round <= r_round + 4'd1;
      end
      if (w_start) begin
        r_duck <= '0;
      end else if ((r_state == ST_SHOW)
                   && (w_nxt == ST_SPAWN)) begin
        r_duck <= r_duck + 4'd1;
      end else if ((r_state == ST_ROUND_END)
                   && bus.game_enable) begin
        r_duck <= '0;
      end
    end
  end

  // outputs decode the next state so they line up with r_state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hunt     <= 1'b0;
      r_respawn  <= 1'b0;
      r_bird     <= 1'b0;
      r_laugh    <= 1'b0;
      r_finished <= 1'b0;
      r_state_o  <= '0;
    end else begin
      r_hunt     <= (w_nxt == ST_FLY);
      r_respawn  <= (w_nxt == ST_SPAWN);
      r_bird     <= (w_nxt == ST_SHOW) && w_lh_nxt;
      r_laugh    <= (w_nxt == ST_SHOW) && !w_lh_nxt;
      r_finished <= (w_nxt == ST_DONE);
      r_state_o  <= w_nxt;
    end
  end

  assign bus.hunt_start      = r_hunt;
  assign bus.duck_respawn    = r_respawn;
  assign bus.dog_bird_enable = r_bird;
  assign bus.dog_laugh       = r_laugh;
  assign bus.enemy_score     = r_score;
  assign bus.round_num       = r_round;
  assign bus.duck_num        = r_duck;
  assign bus.rounds_finished = r_finished;
  assign bus.state_o         = r_state_o;

endmodule

// File: tb/tb_duck_round_scheduler.sv
// tb_duck_round_scheduler: directed bench for the round scheduler
// with a short 2x2 game and a frame tick every 4 cycles.
module tb_duck_round_scheduler;

`ifdef DUCK_SCHED_SPEEDUP_EN
  localparam int R1_FLY = 4;
`else
  localparam int R1_FLY = 5;
`endif

  localparam int SIG_RESPAWN = 0;
  localparam int SIG_HUNT    = 1;
  localparam int SIG_BIRD    = 2;
  localparam int SIG_LAUGH   = 3;
  localparam int SIG_FIN     = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick_en = 1'b0;
  int   tdiv = 0;
  int   checks = 0;
  int   errors = 0;

  duck_round_scheduler_if bus ();

  duck_round_scheduler #(
    .DUCKS_PER_ROUND   (2),
    .ROUNDS            (2),
    .INTRO_FRAMES      (3),
    .FLIGHT_FRAMES     (5),
    .FALL_FRAMES       (2),
    .SHOW_FRAMES       (2),
    .SPEEDUP_STEP      (2),
    .MIN_FLIGHT_FRAMES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    bus.frame_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tick_en) begin
        tdiv = (tdiv == 3) ? 0 : tdiv + 1;
        bus.frame_tick = (tdiv == 3);
      end else begin
        bus.frame_tick = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      SIG_RESPAWN: return bus.duck_respawn;
      SIG_HUNT:    return bus.hunt_start;
      SIG_BIRD:    return bus.dog_bird_enable;
      SIG_LAUGH:   return bus.dog_laugh;
      default:     return bus.rounds_finished;
    endcase
  endfunction

  // ticks seen before the signal goes high, starting at this negedge
  task automatic wait_sig(input int which, output int ticks,
                          output logic ok);
    ticks = 0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (sig(which)) begin
        ok = 1'b1;
        break;
      end
      if (bus.frame_tick) ticks++;
      @(negedge clk);
    end
  endtask

  // ticks seen while the signal stays high
  task automatic hold_sig(input int which, output int ticks,
                          output logic ok);
    ticks = 0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!sig(which)) begin
        ok = 1'b1;
        break;
      end
      if (bus.frame_tick) ticks++;
      @(negedge clk);
    end
  endtask

  task automatic start_game();
    bus.game_enable = 1'b1;
    bus.game_start  = 1'b1;
    @(negedge clk);
    bus.game_start  = 1'b0;
  endtask

  task automatic enables(output logic [4:0] v);
    v = {bus.hunt_start, bus.duck_respawn, bus.dog_bird_enable,
         bus.dog_laugh, bus.rounds_finished};
  endtask

  initial begin
    int         tk;
    int         hi;
    logic       ok;
    logic [4:0] en;

    bus.game_enable = 1'b0;
    bus.game_start  = 1'b0;
    bus.intro_done  = 1'b0;
    bus.duck_killed = 1'b0;
    #2 rst = 1'b0;

    @(negedge clk);
    enables(en);
    chk("rst_enables", en, 0);
    chk("rst_score", bus.enemy_score, 0);
    chk("rst_round", bus.round_num, 0);
    chk("rst_duck", bus.duck_num, 0);
    chk("rst_state", bus.state_o, 0);
    rst = 1'b1;
    @(negedge clk);
    tick_en = 1'b1;

    // game 1: no kills, every duck escapes
    start_game();
    for (int d = 0; d < 4; d++) begin
      wait_sig(SIG_RESPAWN, tk, ok);
      chk($sformatf("g1_respawn_seen_%0d", d), ok, 1);
      chk($sformatf("g1_pre_ticks_%0d", d), tk,
          (d == 0 || d == 2) ? 3 : 0);
      chk($sformatf("g1_round_%0d", d), bus.round_num, d / 2);
      chk($sformatf("g1_duck_%0d", d), bus.duck_num, d % 2);
      @(negedge clk);
      chk($sformatf("g1_respawn_1cyc_%0d", d), bus.duck_respawn, 0);
      chk($sformatf("g1_hunt_on_%0d", d), bus.hunt_start, 1);
      hold_sig(SIG_HUNT, tk, ok);
      chk($sformatf("g1_fly_ticks_%0d", d), tk,
          (d < 2) ? 5 : R1_FLY);
      chk($sformatf("g1_score_%0d", d), bus.enemy_score, d + 1);
      wait_sig(SIG_LAUGH, tk, ok);
      chk($sformatf("g1_laugh_seen_%0d", d), ok, 1);
      chk($sformatf("g1_no_bird_%0d", d), bus.dog_bird_enable, 0);
      hold_sig(SIG_LAUGH, tk, ok);
      chk($sformatf("g1_laugh_ticks_%0d", d), tk, 2);
    end
    wait_sig(SIG_FIN, tk, ok);
    chk("g1_finished_seen", ok, 1);
    chk("g1_done_score", bus.enemy_score, 4);
    chk("g1_done_round", bus.round_num, 1);
    chk("g1_done_duck", bus.duck_num, 0);
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      hi += int'(bus.rounds_finished)
            + int'(bus.hunt_start) * 100;
    end
    chk("g1_done_held", hi, 12);

    bus.game_enable = 1'b0;
    @(negedge clk);
    enables(en);
    chk("g1_abort_enables", en, 0);
    chk("g1_abort_state", bus.state_o, 0);
    chk("g1_abort_score_kept", bus.enemy_score, 4);

    // game 2: intro_done shortcut, kill on tick 2, kill at timeout
    bus.intro_done = 1'b1;
    start_game();
    chk("g2_score_cleared", bus.enemy_score, 0);
    @(negedge clk);
    chk("g2_intro_skip_respawn", bus.duck_respawn, 1);
    bus.intro_done = 1'b0;
    @(negedge clk);
    chk("g2_hunt_on", bus.hunt_start, 1);
    tk = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.frame_tick) tk++;
      if (tk == 2) break;
      @(negedge clk);
    end
    bus.duck_killed = 1'b1;
    @(negedge clk);
    bus.duck_killed = 1'b0;
    chk("g2_kill_hunt_off", bus.hunt_start, 0);
    wait_sig(SIG_BIRD, tk, ok);
    chk("g2_bird_seen", ok, 1);
    chk("g2_fall_ticks", tk, 2);
    chk("g2_kill_no_laugh", bus.dog_laugh, 0);
    hold_sig(SIG_BIRD, tk, ok);
    chk("g2_bird_ticks", tk, 2);
    chk("g2_kill_score", bus.enemy_score, 0);

    wait_sig(SIG_RESPAWN, tk, ok);
    chk("g2_d1_duck", bus.duck_num, 1);
    @(negedge clk);
    tk = 0;
    for (int i = 0; i < 60; i++) begin
      if (bus.frame_tick) tk++;
      if (tk == 5) break;
      @(negedge clk);
    end
    @(negedge clk);
    chk("g2_pre_timeout_fly", bus.hunt_start, 1);
    bus.duck_killed = 1'b1;
    @(negedge clk);
    bus.duck_killed = 1'b0;
    chk("g2_tie_hunt_off", bus.hunt_start, 0);
    chk("g2_tie_score", bus.enemy_score, 0);
    wait_sig(SIG_BIRD, tk, ok);
    chk("g2_tie_bird_seen", ok, 1);
    chk("g2_tie_no_laugh", bus.dog_laugh, 0);
    hold_sig(SIG_BIRD, tk, ok);

    wait_sig(SIG_RESPAWN, tk, ok);
    chk("g2_r1_intro_ticks", tk, 3);
    chk("g2_r1_round", bus.round_num, 1);
    @(negedge clk);
    hold_sig(SIG_HUNT, tk, ok);
    chk("g2_r1_fly_ticks", tk, R1_FLY);
    chk("g2_r1_score", bus.enemy_score, 1);
    wait_sig(SIG_LAUGH, tk, ok);
    hold_sig(SIG_LAUGH, tk, ok);
    wait_sig(SIG_RESPAWN, tk, ok);
    @(negedge clk);
    chk("g2_r1d1_hunt", bus.hunt_start, 1);
    bus.game_start = 1'b1;
    @(negedge clk);
    bus.game_start = 1'b0;
    chk("g2_start_ignored_hunt", bus.hunt_start, 1);
    chk("g2_start_ignored_score", bus.enemy_score, 1);
    chk("g2_start_ignored_duck", bus.duck_num, 1);

    bus.game_enable = 1'b0;
    @(negedge clk);
    enables(en);
    chk("g2_abort_enables", en, 0);
    chk("g2_abort_state", bus.state_o, 0);
    chk("g2_abort_score", bus.enemy_score, 1);
    chk("g2_abort_round", bus.round_num, 1);

    // game 3: restart clears, then async reset mid-flight
    start_game();
    chk("g3_score_cleared", bus.enemy_score, 0);
    chk("g3_round_cleared", bus.round_num, 0);
    chk("g3_duck_cleared", bus.duck_num, 0);
    wait_sig(SIG_RESPAWN, tk, ok);
    @(negedge clk);
    chk("g3_hunt_on", bus.hunt_start, 1);
    #1 rst = 1'b0;
    #1;
    enables(en);
    chk("g3_async_rst_enables", en, 0);
    chk("g3_async_rst_state", bus.state_o, 0);
    rst = 1'b1;
    tick_en = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/duck_round_scheduler.md
Name: duck_round_scheduler

Overview:
- Sequences one game of duck hunt: dog intro, duck spawn, flight with timeout, hit or escape, dog reaction, next duck, next round.
- Drives the hunt/dog enables that feed duck_ctl, duck_game_logic and dog_bird_ctl.
- Replaces the fixed enemy score with a live escape count.
- Sits between game_control_fsm and the game-control datapath; all timing is counted in frames using a one-cycle-per-frame tick.

Parameters:
DUCKS_PER_ROUND, 10, ducks spawned per round (2..15)
ROUNDS, 5, rounds per game (1..15)
INTRO_FRAMES, 120, maximum intro length if intro_done never arrives
FLIGHT_FRAMES, 300, frames before a live duck escapes
FALL_FRAMES, 40, hit-to-show delay (duck falling)
SHOW_FRAMES, 60, dog reaction display length
SPEEDUP_STEP, 30, per-round flight reduction (SPEEDUP_EN only)
MIN_FLIGHT_FRAMES, 120, flight floor (SPEEDUP_EN only)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
game_enable  in  1  game phase active (from game_control_fsm)
game_start  in  1  one-cycle pulse at game_enable rising edge
frame_tick  in  1  one-cycle pulse per frame
intro_done  in  1  dog intro animation finished (level)
duck_killed  in  1  hit reported by game logic (level or pulse)
hunt_start  out  1  duck flying, shooting allowed
duck_respawn  out  1  one-cycle pulse: new duck, load new lfsr position
dog_bird_enable  out  1  dog shows caught duck
dog_laugh  out  1  dog laughs after an escape
enemy_score  out  7  escaped ducks, saturates at 99
round_num  out  4  current round, 0-based
duck_num  out  4  duck index within the round, 0-based
rounds_finished  out  1  all rounds done, held high
state_o  out  4  encoded state, for debug

Behaviour:
- Reset value of every output is 0. The state resets to IDLE.
- One frame counter, 9 bits minimum, sized from the largest frame parameter. It clears on every state change and increments only on frame_tick.
- States and transitions:
  - IDLE: on game_start, clear enemy_score, round_num and duck_num, then go to INTRO.
  - INTRO: go to SPAWN when intro_done=1, or when the counter reaches INTRO_FRAMES, whichever comes first.
  - SPAWN: lasts exactly 1 cycle. duck_respawn=1. Then go to FLY.
  - FLY: hunt_start=1.
    - duck_killed=1 → HIT.
    - Otherwise, counter reaching the flight limit → ESCAPE, and enemy_score+1 in the same cycle (saturating).
    - If the kill and the timeout land in the same cycle, the kill wins and enemy_score is unchanged.
  - HIT: hunt_start=0. After FALL_FRAMES → SHOW, with the internal flag last_hit=1.
  - ESCAPE: zero-length (1 cycle). Sets last_hit=0, then → SHOW.
  - SHOW: dog_bird_enable=last_hit and dog_laugh=!last_hit. After SHOW_FRAMES:
    - if duck_num==DUCKS_PER_ROUND-1 → ROUND_END;
    - otherwise duck_num+1 → SPAWN.
  - ROUND_END: lasts 1 cycle. duck_num=0.
    - If round_num==ROUNDS-1 → DONE.
    - Otherwise round_num+1 → INTRO.
  - DONE: rounds_finished=1. All other enables are 0. Stays here until game_enable=0.
- Abort: game_enable=0 in any state → IDLE on the next edge. All enables drop, counters and enemy_score are kept (the end screen shows enemy_score), and rounds_finished clears.
- game_start while not in IDLE is ignored.
- Every output is registered, 1 cycle after the state decision. duck_respawn is exactly one cycle wide.
- Asynchronous reset mid-operation returns to IDLE with all outputs 0 immediately.

Optional Feature:
- Macro: DUCK_SCHED_SPEEDUP_EN.
- Defined: flight limit = max(FLIGHT_FRAMES - round_num*SPEEDUP_STEP, MIN_FLIGHT_FRAMES). It is computed in ROUND_END / IDLE into a register, so there is no combinational multiply in the FLY path.
- Undefined: flight limit = FLIGHT_FRAMES in every round, and the SPEEDUP parameters are unused.

Decomposition:
- vga_pkg gets:
  - typedef enum sched_state_t {IDLE, INTRO, SPAWN, FLY, HIT, ESCAPE, SHOW, ROUND_END, DONE};
  - the default frame constants;
  - ENEMY_SCORE_MAX=99.
- One sub-module, frame_timer: counter with clear, tick enable and a terminal-count compare output. It is instantiated once and compared against a muxed limit.

Test Plan (DUCKS_PER_ROUND=2, ROUNDS=2, INTRO_FRAMES=3, FLIGHT_FRAMES=5, FALL_FRAMES=2, SHOW_FRAMES=2, frame_tick every 4 cycles):
- Reset then game_start, intro_done stays 0 → INTRO for 3 ticks → one duck_respawn pulse → hunt_start=1.
- No kills for a full game → 4 escapes: enemy_score=4, dog_laugh high 2 ticks each time, then rounds_finished=1 held.
- duck_killed asserted on tick 2 of FLY → hunt_start drops next cycle; after 2 ticks dog_bird_enable=1 for 2 ticks; enemy_score unchanged.
- duck_killed asserted in the same cycle as the timeout → HIT taken, enemy_score stays 0.
- game_enable deasserted mid-FLY → IDLE next edge, all enables 0, enemy_score retained; next game_start clears it to 0.
- With DUCK_SCHED_SPEEDUP_EN, FLIGHT_FRAMES=5, SPEEDUP_STEP=2, MIN=4 → round 0 escape after 5 ticks, round 1 after 4 ticks (floor applies).
